// File: rtl/uart_rx_dma.sv
// UART receive stage: deserialises 8N1 bytes, stores them into DPRAM port B,
// then reports the received length and a status byte to the register block.
module uart_rx_dma #(
    parameter int unsigned CLK_FREQ      = 100000000,
    parameter int unsigned BAUD          = 115200,
    parameter int unsigned IDLE_BITS     = 20,
    parameter logic [7:0]  LEN_REG_ADDR  = 8'h10,
    parameter logic [7:0]  STAT_REG_ADDR = 8'h11
) (
    input  logic        Clk,
    input  logic        Rst_n,
    input  logic        uart_rx,
    input  logic        R_Rx_En,
    input  logic [7:0]  R_Rx_AddrH,
    input  logic [7:0]  R_Rx_AddrL,
    input  logic [7:0]  R_Rx_MaxLen,
    output logic        R_Rx_Busy,
    output logic [14:0] RAM_Addr,
    output logic [7:0]  RAM_Write_Data,
    output logic        RAM_Write_En,
    output logic [7:0]  Reg_Addr,
    output logic [7:0]  Reg_Write_Data,
    output logic        Reg_Write_En
);

    localparam int unsigned BAUD_DIV   = CLK_FREQ / BAUD;
    localparam int unsigned HALF_DIV   = BAUD_DIV / 2;
    localparam int unsigned IDLE_LIMIT = IDLE_BITS * BAUD_DIV;
    localparam int unsigned TW         = $clog2(BAUD_DIV + 1);
    localparam int unsigned IW         = $clog2(IDLE_LIMIT + 1);

    typedef enum logic [2:0] {
        IDLE, ARMED, START, DATA, STOP, STORE, WB_LEN, WB_STAT
    } state_t;

    state_t        state_q, state_d;
    logic          rx_meta, rx_sync, rx_prev;
    logic          en_q;
    logic [TW-1:0] tick_q, tick_d;
    logic [IW-1:0] idle_q, idle_d;
    logic [2:0]    bit_q, bit_d;
    logic [7:0]    shift_q, shift_d;
    logic [14:0]   base_q, base_d;
    logic [8:0]    max_q, max_d;
    logic [8:0]    count_q, count_d;
    logic          ferr_q, ferr_d;
    logic          busy_d;
    logic [14:0]   ram_addr_d;
    logic [7:0]    ram_data_d;
    logic          ram_we_d;
    logic [7:0]    reg_addr_d;
    logic [7:0]    reg_data_d;
    logic          reg_we_d;
    logic          rx_fall;
    logic          abort;
    logic          unused_addr_msb;

    // Only 15 address bits exist on the RAM side.
    assign unused_addr_msb = R_Rx_AddrH[7];

    assign rx_fall = rx_prev & ~rx_sync;
    assign abort   = (state_q inside {ARMED, START, DATA, STOP, STORE}) && !R_Rx_En;

    // State, datapath and registered outputs.
    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            rx_meta        <= 1'b1;
            rx_sync        <= 1'b1;
            rx_prev        <= 1'b1;
            en_q           <= 1'b0;
            state_q        <= IDLE;
            tick_q         <= '0;
            idle_q         <= '0;
            bit_q          <= '0;
            shift_q        <= '0;
            base_q         <= '0;
            max_q          <= '0;
            count_q        <= '0;
            ferr_q         <= 1'b0;
            R_Rx_Busy      <= 1'b0;
            RAM_Addr       <= '0;
            RAM_Write_Data <= '0;
            RAM_Write_En   <= 1'b0;
            Reg_Addr       <= '0;
            Reg_Write_Data <= '0;
            Reg_Write_En   <= 1'b0;
        end else begin
            rx_meta        <= uart_rx;
            rx_sync        <= rx_meta;
            rx_prev        <= rx_sync;
            en_q           <= R_Rx_En;
            state_q        <= state_d;
            tick_q         <= tick_d;
            idle_q         <= idle_d;
            bit_q          <= bit_d;
            shift_q        <= shift_d;
            base_q         <= base_d;
            max_q          <= max_d;
            count_q        <= count_d;
            ferr_q         <= ferr_d;
            R_Rx_Busy      <= busy_d;
            RAM_Addr       <= ram_addr_d;
            RAM_Write_Data <= ram_data_d;
            RAM_Write_En   <= ram_we_d;
            Reg_Addr       <= reg_addr_d;
            Reg_Write_Data <= reg_data_d;
            Reg_Write_En   <= reg_we_d;
        end
    end

    // Next-state logic; strobes are raised on the transition so they are
    // visible in the same cycle the FSM sits in STORE / WB_LEN / WB_STAT.
    always_comb begin
        state_d    = state_q;
        tick_d     = tick_q;
        idle_d     = idle_q;
        bit_d      = bit_q;
        shift_d    = shift_q;
        base_d     = base_q;
        max_d      = max_q;
        count_d    = count_q;
        ferr_d     = ferr_q;
        busy_d     = R_Rx_Busy;
        ram_addr_d = RAM_Addr;
        ram_data_d = RAM_Write_Data;
        ram_we_d   = 1'b0;
        reg_addr_d = Reg_Addr;
        reg_data_d = Reg_Write_Data;
        reg_we_d   = 1'b0;

        if (abort) begin
            state_d = IDLE;
            busy_d  = 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (R_Rx_En && !en_q) begin
                        base_d  = {R_Rx_AddrH[6:0], R_Rx_AddrL};
                        max_d   = (R_Rx_MaxLen == 8'd0) ? 9'd256 : {1'b0, R_Rx_MaxLen};
                        count_d = '0;
                        ferr_d  = 1'b0;
                        idle_d  = '0;
                        busy_d  = 1'b1;
                        state_d = ARMED;
                    end
                end
                ARMED: begin
                    if (rx_fall) begin
                        tick_d  = TW'(HALF_DIV);
                        idle_d  = '0;
                        state_d = START;
                    end else if (count_q != 9'd0) begin
                        if (idle_q == IW'(IDLE_LIMIT - 1)) begin
                            reg_addr_d = LEN_REG_ADDR;
                            reg_data_d = count_q[7:0];
                            reg_we_d   = 1'b1;
                            state_d    = WB_LEN;
                        end else begin
                            idle_d = idle_q + IW'(1);
                        end
                    end
                end
                START: begin
                    if (tick_q == '0) begin
                        if (!rx_sync) begin
                            tick_d  = TW'(BAUD_DIV - 1);
                            bit_d   = '0;
                            state_d = DATA;
                        end else begin
                            idle_d  = '0;
                            state_d = ARMED;
                        end
                    end else begin
                        tick_d = tick_q - TW'(1);
                    end
                end
                DATA: begin
                    if (tick_q == '0) begin
                        shift_d = {rx_sync, shift_q[7:1]};
                        tick_d  = TW'(BAUD_DIV - 1);
                        if (bit_q == 3'd7) begin
                            state_d = STOP;
                        end else begin
                            bit_d = bit_q + 3'd1;
                        end
                    end else begin
                        tick_d = tick_q - TW'(1);
                    end
                end
                STOP: begin
                    if (tick_q == '0) begin
                        if (rx_sync) begin
                            ram_addr_d = base_q + 15'(count_q);
                            ram_data_d = shift_q;
                            ram_we_d   = 1'b1;
                            state_d    = STORE;
                        end else begin
                            ferr_d  = 1'b1;
                            idle_d  = '0;
                            state_d = ARMED;
                        end
                    end else begin
                        tick_d = tick_q - TW'(1);
                    end
                end
                STORE: begin
                    count_d = count_q + 9'd1;
                    idle_d  = '0;
                    if (count_d == max_q) begin
                        reg_addr_d = LEN_REG_ADDR;
                        reg_data_d = count_d[7:0];
                        reg_we_d   = 1'b1;
                        state_d    = WB_LEN;
                    end else begin
                        state_d = ARMED;
                    end
                end
                WB_LEN: begin
                    reg_addr_d = STAT_REG_ADDR;
                    reg_data_d = {5'b0, (count_q == max_q), ferr_q, 1'b1};
                    reg_we_d   = 1'b1;
                    state_d    = WB_STAT;
                end
                WB_STAT: begin
                    busy_d  = 1'b0;
                    state_d = IDLE;
                end
                default: begin
                    state_d = IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_rx_dma.sv
// Scoreboard bench for uart_rx_dma: a frame-level model queues the expected
// RAM and register writes; a monitor pops and compares on every strobe.
module tb_uart_rx_dma;

    localparam int unsigned CLK_FREQ   = 1600000;
    localparam int unsigned BAUD       = 100000;
    localparam int unsigned IDLE_BITS  = 20;
    localparam int          BAUD_DIV   = CLK_FREQ / BAUD;
    localparam int          IDLE_LIMIT = IDLE_BITS * BAUD_DIV;

    logic        Clk;
    logic        Rst_n;
    logic        uart_rx;
    logic        R_Rx_En;
    logic [7:0]  R_Rx_AddrH;
    logic [7:0]  R_Rx_AddrL;
    logic [7:0]  R_Rx_MaxLen;
    logic        R_Rx_Busy;
    logic [14:0] RAM_Addr;
    logic [7:0]  RAM_Write_Data;
    logic        RAM_Write_En;
    logic [7:0]  Reg_Addr;
    logic [7:0]  Reg_Write_Data;
    logic        Reg_Write_En;

    uart_rx_dma #(
        .CLK_FREQ (CLK_FREQ),
        .BAUD     (BAUD),
        .IDLE_BITS(IDLE_BITS)
    ) dut (
        .Clk           (Clk),
        .Rst_n         (Rst_n),
        .uart_rx       (uart_rx),
        .R_Rx_En       (R_Rx_En),
        .R_Rx_AddrH    (R_Rx_AddrH),
        .R_Rx_AddrL    (R_Rx_AddrL),
        .R_Rx_MaxLen   (R_Rx_MaxLen),
        .R_Rx_Busy     (R_Rx_Busy),
        .RAM_Addr      (RAM_Addr),
        .RAM_Write_Data(RAM_Write_Data),
        .RAM_Write_En  (RAM_Write_En),
        .Reg_Addr      (Reg_Addr),
        .Reg_Write_Data(Reg_Write_Data),
        .Reg_Write_En  (Reg_Write_En)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    typedef struct {
        bit          is_reg;
        logic [14:0] addr;
        logic [7:0]  data;
        int          gap_min;
        int          gap_max;
    } exp_t;

    typedef logic [7:0] bytes_t[$];
    typedef bit         flags_t[$];

    exp_t   exp_q[$];
    int     n_cmp = 0;
    int     n_bad = 0;
    longint cyc = 0;
    longint last_cyc = 0;
    int     ram_writes = 0;
    int     reg_writes = 0;

    task automatic check(input string name, input bit ok, input string detail);
        n_cmp++;
        if (!ok) begin
            n_bad++;
            $display("FAIL %s: %s", name, detail);
        end
    endtask

    // Monitor: every strobe must match the head of the expectation queue.
    always @(negedge Clk) begin
        exp_t   e;
        longint gap;
        cyc++;
        if (RAM_Write_En && Reg_Write_En)
            check("strobe_overlap", 1'b0, "RAM and Reg strobes high together");
        if (RAM_Write_En || Reg_Write_En) begin
            gap = cyc - last_cyc;
            if (exp_q.size() == 0) begin
                check("unexpected_write", 1'b0,
                      $sformatf("got ram=%0b addr=%h/%h data=%h/%h, want no write",
                                RAM_Write_En, RAM_Addr, Reg_Addr, RAM_Write_Data, Reg_Write_Data));
            end else begin
                e = exp_q.pop_front();
                if (e.is_reg)
                    check("reg_write", Reg_Write_En && Reg_Addr == e.addr[7:0] &&
                          Reg_Write_Data == e.data && gap >= e.gap_min && gap <= e.gap_max,
                          $sformatf("got en=%0b addr=%h data=%h gap=%0d, want addr=%h data=%h gap=%0d..%0d",
                                    Reg_Write_En, Reg_Addr, Reg_Write_Data, gap,
                                    e.addr[7:0], e.data, e.gap_min, e.gap_max));
                else
                    check("ram_write", RAM_Write_En && RAM_Addr == e.addr && RAM_Write_Data == e.data,
                          $sformatf("got en=%0b addr=%h data=%h, want addr=%h data=%h",
                                    RAM_Write_En, RAM_Addr, RAM_Write_Data, e.addr, e.data));
            end
            last_cyc = cyc;
            if (RAM_Write_En) ram_writes++;
            else              reg_writes++;
        end
    end

    // Frame-level reference: good bytes land at base+n (15-bit wrap), then
    // the length and a done/ferr/limit status byte are reported.
    task automatic model_frame(input logic [14:0] base, input logic [7:0] ml,
                               input bytes_t bq, input flags_t fq, input bit idle_end);
        exp_t e;
        int   mx = (ml == 8'd0) ? 256 : int'(ml);
        int   stored = 0;
        bit   fe = 1'b0;
        for (int i = 0; i < bq.size(); i++) begin
            if (!fq[i]) fe = 1'b1;
            else if (stored < mx) begin
                e.is_reg = 1'b0; e.addr = 15'(base + 15'(stored)); e.data = bq[i];
                e.gap_min = 0; e.gap_max = 32'h7fffffff;
                exp_q.push_back(e);
                stored++;
            end
        end
        e.is_reg = 1'b1; e.addr = 15'h0010; e.data = 8'(stored);
        e.gap_min = idle_end ? IDLE_LIMIT : 1;
        e.gap_max = idle_end ? IDLE_LIMIT + BAUD_DIV : 1;
        exp_q.push_back(e);
        e.is_reg = 1'b1; e.addr = 15'h0011; e.data = {5'b0, stored == mx, fe, 1'b1};
        e.gap_min = 1; e.gap_max = 1;
        exp_q.push_back(e);
    endtask

    task automatic send_bit(input logic v);
        uart_rx = v;
        repeat (BAUD_DIV) @(negedge Clk);
    endtask

    task automatic send_byte(input logic [7:0] b, input bit good, input int gap);
        send_bit(1'b0);
        for (int i = 0; i < 8; i++) send_bit(b[i]);
        send_bit(good);
        uart_rx = 1'b1;
        repeat (gap) @(negedge Clk);
    endtask

    task automatic arm(input logic [14:0] base, input logic [7:0] ml);
        R_Rx_AddrH  = {1'($urandom_range(0, 1)), base[14:8]};
        R_Rx_AddrL  = base[7:0];
        R_Rx_MaxLen = ml;
        R_Rx_En     = 1'b1;
        repeat (2) @(negedge Clk);
        check("busy_after_arm", R_Rx_Busy == 1'b1, $sformatf("got busy=%0b, want 1", R_Rx_Busy));
    endtask

    task automatic wait_busy_low(input string name, input int limit);
        int n = 0;
        while (R_Rx_Busy && n < limit) begin
            @(negedge Clk);
            n++;
        end
        check(name, !R_Rx_Busy, $sformatf("got busy=%0b after %0d cycles, want 0", R_Rx_Busy, n));
    endtask

    task automatic drain_check(input string name);
        repeat (2) @(negedge Clk);
        check(name, exp_q.size() == 0, $sformatf("got %0d pending writes, want 0", exp_q.size()));
        exp_q.delete();
    endtask

    task automatic run_frame(input logic [14:0] base, input logic [7:0] ml, input bytes_t bq,
                             input flags_t fq, input bit idle_end, input int gap, input bit drop_en);
        int r0;
        model_frame(base, ml, bq, fq, idle_end);
        arm(base, ml);
        for (int i = 0; i < bq.size(); i++)
            send_byte(bq[i], fq[i], (i == bq.size() - 1) ? 0 : (fq[i] ? gap : gap + BAUD_DIV));
        if (idle_end) begin
            r0 = reg_writes;
            repeat (IDLE_LIMIT - 2 * BAUD_DIV) @(negedge Clk);
            check("no_early_writeback", reg_writes == r0,
                  $sformatf("got %0d reg writes, want %0d", reg_writes, r0));
        end
        wait_busy_low("frame_done", IDLE_LIMIT + 4 * BAUD_DIV);
        drain_check("frame_drained");
        if (drop_en) begin
            R_Rx_En = 1'b0;
            repeat (3) @(negedge Clk);
        end
    endtask

    initial begin
        #(10 * 200000);
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bytes_t bq;
        flags_t fq;
        int     r0;
        int     w0;
        int     n;
        int     ngood;
        bit     idle_end;
        logic [7:0]  ml;
        logic [14:0] base;

        Rst_n = 1'b0; uart_rx = 1'b1; R_Rx_En = 1'b0;
        R_Rx_AddrH = 8'h0; R_Rx_AddrL = 8'h0; R_Rx_MaxLen = 8'h0;
        repeat (3) @(negedge Clk);
        check("reset_outputs", {R_Rx_Busy, RAM_Addr, RAM_Write_Data, RAM_Write_En,
                                Reg_Addr, Reg_Write_Data, Reg_Write_En} == '0, "outputs not all zero");
        Rst_n = 1'b1;
        repeat (3) @(negedge Clk);

        // Length-limited frame; then a level held high must not re-arm.
        bq = {8'hA5, 8'h3C, 8'hFF}; fq = {1'b1, 1'b1, 1'b1};
        run_frame(15'h0100, 8'd3, bq, fq, 1'b0, 5, 1'b0);
        w0 = ram_writes;
        send_byte(8'h77, 1'b1, BAUD_DIV);
        check("no_rearm_write", ram_writes == w0, $sformatf("got %0d ram writes, want %0d", ram_writes, w0));
        check("no_rearm_busy", R_Rx_Busy == 1'b0, $sformatf("got busy=%0b, want 0", R_Rx_Busy));
        R_Rx_En = 1'b0;
        repeat (3) @(negedge Clk);

        // MaxLen 0 frame ended by idle time.
        bq = {8'h11, 8'h22}; fq = {1'b1, 1'b1};
        run_frame(15'h0200, 8'd0, bq, fq, 1'b1, 3, 1'b1);

        // Framing error followed by a good byte.
        bq = {8'h55, 8'h66}; fq = {1'b0, 1'b1};
        run_frame(15'h0300, 8'd0, bq, fq, 1'b1, 4, 1'b1);

        // Address wrap at the top of the RAM.
        bq = {8'h01, 8'h02}; fq = {1'b1, 1'b1};
        run_frame(15'h7FFF, 8'd2, bq, fq, 1'b0, 0, 1'b1);

        // Short low glitch is a false start; receiver stays armed.
        bq = {8'hC3}; fq = {1'b1};
        model_frame(15'h0400, 8'd1, bq, fq, 1'b0);
        arm(15'h0400, 8'd1);
        w0 = ram_writes;
        uart_rx = 1'b0;
        repeat (BAUD_DIV / 4) @(negedge Clk);
        uart_rx = 1'b1;
        repeat (3 * BAUD_DIV) @(negedge Clk);
        check("glitch_no_write", ram_writes == w0, $sformatf("got %0d ram writes, want %0d", ram_writes, w0));
        check("glitch_still_busy", R_Rx_Busy == 1'b1, $sformatf("got busy=%0b, want 1", R_Rx_Busy));
        send_byte(8'hC3, 1'b1, 0);
        wait_busy_low("glitch_frame_done", 4 * BAUD_DIV);
        drain_check("glitch_drained");
        R_Rx_En = 1'b0;
        repeat (3) @(negedge Clk);

        // Abort after one byte: byte stays, no write-back.
        bq = {8'h9A}; fq = {1'b1};
        model_frame(15'h0500, 8'd4, bq, fq, 1'b0);
        void'(exp_q.pop_back());
        void'(exp_q.pop_back());
        arm(15'h0500, 8'd4);
        send_byte(8'h9A, 1'b1, 0);
        R_Rx_En = 1'b0;
        @(negedge Clk);
        check("abort_busy", R_Rx_Busy == 1'b0, $sformatf("got busy=%0b, want 0", R_Rx_Busy));
        r0 = reg_writes;
        repeat (IDLE_LIMIT + 2 * BAUD_DIV) @(negedge Clk);
        check("abort_no_writeback", reg_writes == r0, $sformatf("got %0d reg writes, want %0d", reg_writes, r0));
        drain_check("abort_drained");

        // Asynchronous reset in the middle of a byte.
        arm(15'h1234, 8'd2);
        uart_rx = 1'b0;
        repeat (3 * BAUD_DIV) @(negedge Clk);
        #2 Rst_n = 1'b0;
        #1;
        check("midbyte_reset", {R_Rx_Busy, RAM_Addr, RAM_Write_Data, RAM_Write_En,
                                Reg_Addr, Reg_Write_Data, Reg_Write_En} == '0,
              $sformatf("got busy=%0b ram_addr=%h reg_data=%h, want all zero", R_Rx_Busy, RAM_Addr, Reg_Write_Data));
        uart_rx = 1'b1;
        R_Rx_En = 1'b0;
        repeat (2) @(negedge Clk);
        Rst_n = 1'b1;
        repeat (3) @(negedge Clk);

        // Randomised frames.
        for (int k = 0; k < 6; k++) begin
            base = (k % 3 == 0) ? 15'h7FFE : 15'($urandom_range(0, 32767));
            n = $urandom_range(1, 4);
            bq.delete(); fq.delete();
            ngood = 0;
            for (int i = 0; i < n; i++) begin
                bq.push_back(8'($urandom));
                fq.push_back((i == n - 1) ? 1'b1 : ($urandom_range(0, 9) != 0));
                if (fq[i]) ngood++;
            end
            idle_end = 1'($urandom_range(0, 1));
            if (!idle_end)              ml = 8'(ngood);
            else if ($urandom_range(0, 1) == 0) ml = 8'd0;
            else                        ml = 8'(ngood + $urandom_range(1, 20));
            run_frame(base, ml, bq, fq, idle_end, $urandom_range(0, 2 * BAUD_DIV), 1'b1);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/uart_rx_dma.md
Name: uart_rx_dma

Overview:
UART receive stage that fills the shared DPRAM from the serial side, on the same port-B path and register conventions as the transmit peripheral. The SPI host arms it through the register block by giving a RAM base address and a maximum length. It deserialises 8N1 bytes from uart_rx and writes each good byte into DPRAM. At frame end it writes the received length and a status byte back into the register block, where the SPI host reads them.

Parameters:
CLK_FREQ  100000000  Clk frequency in Hz
BAUD  115200  line rate; BAUD_DIV = CLK_FREQ/BAUD (868 at defaults), integer-truncated
IDLE_BITS  20  idle bit-times after the last stop bit that end a frame
LEN_REG_ADDR  8'h10  register address for the received length write-back
STAT_REG_ADDR  8'h11  register address for the status write-back

Ports:
Clk  in  1  system clock (100 MHz domain)
Rst_n  in  1  asynchronous active-low reset
uart_rx  in  1  serial input, asynchronous, idles high
R_Rx_En  in  1  arm level from the register block
R_Rx_AddrH  in  8  RAM base address high byte; bits [6:0] used
R_Rx_AddrL  in  8  RAM base address low byte
R_Rx_MaxLen  in  8  maximum bytes per frame; 0 means 256
R_Rx_Busy  out  1  high from arm until write-back completes
RAM_Addr  out  15  DPRAM address
RAM_Write_Data  out  8  DPRAM write data
RAM_Write_En  out  1  DPRAM write strobe, one cycle per byte
Reg_Addr  out  8  register write address
Reg_Write_Data  out  8  register write data
Reg_Write_En  out  1  register write strobe

Behaviour:
- Reset: all outputs 0; state IDLE; uart_rx synchroniser flops preset to 1.
- uart_rx passes through a 2-FF synchroniser; a falling edge is detected on the synchronised signal.
- States: IDLE, ARMED, START, DATA, STOP, STORE, WB_LEN, WB_STAT.
- IDLE: on the rising edge of R_Rx_En:
  - latch base = {AddrH[6:0], AddrL} and max = (MaxLen == 0 ? 256 : MaxLen);
  - clear count (9 bits) and the ferr flag;
  - set R_Rx_Busy = 1 and go to ARMED.
- ARMED:
  - Falling edge -> START, bit counter loaded with BAUD_DIV/2; idle timer cleared.
  - Otherwise, if count > 0, the idle timer counts. At IDLE_BITS*BAUD_DIV cycles it goes to WB_LEN. With count == 0 the timer never fires.
- START: at mid-bit, synchronised line low -> DATA. If high, it was a false start -> back to ARMED with nothing written.
- DATA: 8 samples, each BAUD_DIV cycles apart, LSB first.
- STOP: sample BAUD_DIV cycles after the last data bit.
  - Line 1 -> STORE.
  - Line 0 -> framing error: discard the byte, set ferr, go to ARMED.
- STORE (1 cycle):
  - RAM_Addr = (base + count) mod 2^15, which wraps from 0x7FFF to 0x0000;
  - RAM_Write_Data = byte; RAM_Write_En = 1; count increments;
  - if the new count == max -> WB_LEN, else ARMED.
  - STORE is entered mid stop bit, so the next start edge is never missed.
- WB_LEN (1 cycle): Reg_Addr = LEN_REG_ADDR, Reg_Write_Data = count[7:0] (256 reports as 0), Reg_Write_En = 1.
- WB_STAT (1 cycle): Reg_Addr = STAT_REG_ADDR, Reg_Write_En = 1, Reg_Write_Data built as:
  - bit0 = 1 (done);
  - bit1 = ferr;
  - bit2 = (count == max) (length limit hit);
  - bits[7:3] = 0.
  Then R_Rx_Busy = 0 and the state goes to IDLE.
- Strobes: RAM_Write_En and Reg_Write_En are single-cycle pulses and are never high in the same cycle. RAM_Addr, RAM_Write_Data, Reg_Addr and Reg_Write_Data hold their last values otherwise.
- R_Rx_En low while in any state from ARMED to STORE: abort.
  - Next cycle goes to IDLE, Busy = 0, no write-back.
  - Bytes already stored remain in RAM.
  - A byte in progress is dropped.
- R_Rx_En low during WB_LEN/WB_STAT: ignored; the write-back completes.
- Re-arming requires a new rising edge of R_Rx_En. A level held high after completion does not re-arm.
- Latency: the RAM write occurs 1 cycle after the mid-stop sample. WB_LEN follows STORE by 1 cycle when the length limit is hit, or follows the idle-timer expiry by 1 cycle.

Test Plan:
- Arm with base 0x0100 and MaxLen 3, then send 0xA5, 0x3C, 0xFF -> RAM[0x0100..0x0102] = A5, 3C, FF. Then Reg[0x10] = 0x03, Reg[0x11] = 0x05, Busy falls; no idle wait.
- Arm with MaxLen 0 and send 2 bytes (0x11, 0x22), then idle for 20 bit-times (17360 cycles) -> length 0x02, status 0x01. No write-back occurs before 17360 cycles.
- Send 0x55 with the stop bit forced to 0, then a good 0x66 -> only 0x66 is written, at base + 0. Status on idle end = 0x03.
- Base 0x7FFF, MaxLen 2, bytes 0x01, 0x02 -> writes at 0x7FFF then 0x0000; status 0x05.
- Low glitch of 300 cycles (< 434) on uart_rx -> no RAM write, state stays ARMED.
- Drop R_Rx_En after 1 byte of a MaxLen-4 frame -> Busy = 0 the next cycle and no Reg_Write_En. Asserting Rst_n low mid-byte clears all outputs immediately.
